measurement_scheduler: RTL

//   Sequences frequency measurement: owns the gate-window period, counts input edges

---
 rtl/measurement_scheduler.sv | 92 +++++++++
 1 files changed

// File: rtl/measurement_scheduler.sv
// measurement_scheduler: gates input edges over a programmable window and publishes counts over valid/ready
module measurement_scheduler #(
  parameter int BITS = 12,
  parameter int COUNT_BITS = 7,
  parameter int MAX_COUNT = 99,
  parameter int DEFAULT_PERIOD = 1200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  signal,
  input  logic [BITS-1:0]       period,
  input  logic                  period_load,
  output logic [COUNT_BITS-1:0] count,
  output logic                  count_valid,
  input  logic                  count_ready,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy,
  output logic [BITS-1:0]       active_period
);
  typedef enum logic [1:0] {IDLE, GATE, PUBLISH} state_t;
  state_t state;
  logic s1, s2, s3, rise, pending, last, slot_free;
  logic [BITS-1:0] cyc, pending_period, next_period;
  logic [COUNT_BITS-1:0] edges, edges_next;
  assign rise = s2 & ~s3;
  assign next_period = pending ? pending_period : active_period;
  assign last = cyc == active_period - BITS'(1);
  assign edges_next = (edges == COUNT_BITS'(MAX_COUNT)) ? edges : edges + COUNT_BITS'(rise);
  assign slot_free = !count_valid || count_ready;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      {s1, s2, s3} <= '0;
      cyc <= '0;
      edges <= '0;
      count <= '0;
      count_valid <= 1'b0;
      overrun <= 1'b0;
      pending <= 1'b0;
      pending_period <= '0;
      active_period <= BITS'(DEFAULT_PERIOD);
    end else begin
      {s1, s2, s3} <= {signal, s1, s2};
      if (count_valid && count_ready) count_valid <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;
      case (state)
        IDLE: begin
          cyc <= '0;
          edges <= '0;
          if (enable) begin
            active_period <= next_period;
            pending <= 1'b0;
            state <= GATE;
          end
        end
        GATE: begin
          if (!enable) begin
            cyc <= '0;
            edges <= '0;
            state <= IDLE;
          end else begin
            cyc <= cyc + BITS'(1);
            edges <= edges_next;
            if (last) state <= PUBLISH;
          end
        end
        PUBLISH: begin
          if (slot_free) begin
            count <= edges;
            count_valid <= 1'b1;
          end else overrun <= 1'b1;
          cyc <= '0;
          edges <= '0;
          if (enable) begin
            active_period <= next_period;
            pending <= 1'b0;
            state <= GATE;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // a load in the same clk as a boundary stays staged for the following window
      if (period_load && period != '0) begin
        pending <= 1'b1;
        pending_period <= period;
      end
    end
  end
endmodule
